mtimer_irq_gen: RTL and testbench
=================================

Name: mtimer_irq_gen

Overview:
Machine timer and interrupt source block that sits directly upstream of the CSR register file and drives its t_intr and e_intr inputs. It holds a 64-bit mtime counter with a programmable prescaler and a 64-bit mtimecmp compare register, both reachable through a small memory-mapped slave port on the data bus. It also synchronizes the asynchronous external interrupt pin and edge-detects it into a one-cycle request.

Parameters:
DW, 32, bus data width (fixed at 32; mtime and mtimecmp are split into 32-bit halves)
AW, 5, byte address width of the register window
SYNC_STAGES, 2, synchronizer flops on e_irq_i (minimum 2)

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous, active-low reset
sel_i  input  1  bus access strobe for this block
we_i  input  1  1 = write, 0 = read (sampled when sel_i = 1)
addr_i  input  AW  byte address; bits [1:0] ignored
wdata_i  input  DW  write data
rdata_o  output  DW  registered read data
rvalid_o  output  1  rdata_o valid, one-cycle pulse
e_irq_i  input  1  asynchronous external interrupt line, level high
t_intr  output  1  timer interrupt request to the CSR file, level
e_intr  output  1  external interrupt request to the CSR file, one-cycle pulse

Behaviour:
- Register map (byte offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 TEN timer enable, bit1 EEN external enable, other bits read 0), 0x14 PRESCALE (full 32 bits). Offsets 0x18-0x1C read 0 and ignore writes.
- Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, PRESCALE = 0, prescale counter = 0, synchronizer and edge flops = 0, rdata_o = 0, rvalid_o = 0, t_intr = 0, e_intr = 0.
- Writes: when sel_i & we_i, the addressed register is updated on the next posedge. There is no wait state.
- Reads: when sel_i & ~we_i, rdata_o takes the addressed value on the next posedge and rvalid_o = 1 for exactly that cycle. If the next cycle has no read, rvalid_o = 0 and rdata_o holds its value. Back-to-back reads are supported, one result per cycle.
- Prescaler: when TEN = 1, pcnt increments every cycle. When pcnt == PRESCALE, pcnt clears to 0 and a tick fires. PRESCALE = 0 therefore ticks every cycle, and PRESCALE = N ticks every N+1 cycles.
- When TEN = 0, pcnt holds and mtime holds. Writing PRESCALE or CTRL clears pcnt to 0.
- mtime increments by 1 on each tick as a full 64-bit add with carry from LO into HI. It wraps from 2^64-1 to 0.
- A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority: the written half gets wdata_i and the other half keeps its old value, with no increment and no carry that cycle.
- Compare: t_intr is registered as (TEN & (mtime >= mtimecmp)), evaluated on the current register values (unsigned, 64-bit).
  - t_intr asserts one cycle after the condition becomes true.
  - It stays high until mtimecmp is rewritten above mtime or TEN is cleared.
  - It deasserts on the cycle after the register write.
- External path: e_irq_i passes through SYNC_STAGES flops, then one delay flop. e_intr = EEN & sync_out & ~delayed, registered, giving a single-cycle pulse per rising edge.
  - Latency from an e_irq_i rise to e_intr is SYNC_STAGES+1 cycles.
  - A level held high produces only one pulse. A new pulse needs a low period of at least 1 synchronized cycle.
  - Edges that arrive while EEN = 0 are dropped, not queued.
- Simultaneous events: t_intr and e_intr are independent and may be high in the same cycle; prioritising between them is the CSR file's job.
- Reset asserted mid-operation returns every register and output to its reset value immediately, asynchronously. Deassertion is released synchronously to clk_i by the top level.

Test Plan:
1. Reset release → mtime = 0 and MTIMECMP_HI/LO read 0xFFFF_FFFF. Each read gives rvalid_o = 1 exactly one cycle after sel_i; t_intr = 0 and e_intr = 0.
2. PRESCALE = 3, TEN = 1, then read MTIME_LO 40 cycles after the CTRL write → value 10 (±1 for read latency). Cross-check that mtime advances once per 4 cycles.
3. Write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE with PRESCALE = 0 → the next ticks give LO = 0xFFFF_FFFF, then LO = 0 and HI = 1 (carry).
4. MTIMECMP = 20, TEN = 1, PRESCALE = 0, mtime = 0 → t_intr rises at the cycle after mtime reaches 20 and stays high. Writing MTIMECMP_LO = 100 drops t_intr on the following cycle.
5. EEN = 1, pulse e_irq_i high for 5 cycles → exactly one e_intr pulse, 3 cycles after the rise. The same stimulus with EEN = 0 → no pulse.
6. Drop rst_ni mid-count while t_intr = 1 → t_intr, mtime and CTRL clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mtimer_irq_gen.sv
// mtimer_irq_gen: 64-bit machine timer with prescaler, compare interrupt and synchronized external interrupt edge source
module mtimer_irq_gen #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sel_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    input  logic          e_irq_i,
    output logic          t_intr,
    output logic          e_intr
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int IW = AW - 2;

    localparam logic [IW-1:0] R_MTIME_LO = IW'(0);
    localparam logic [IW-1:0] R_MTIME_HI = IW'(1);
    localparam logic [IW-1:0] R_CMP_LO   = IW'(2);
    localparam logic [IW-1:0] R_CMP_HI   = IW'(3);
    localparam logic [IW-1:0] R_CTRL     = IW'(4);
    localparam logic [IW-1:0] R_PRESCALE = IW'(5);

    logic [IW-1:0]   idx;
    logic            wr;
    logic            rd;
    logic            wr_mtime_lo;
    logic            wr_mtime_hi;
    logic            wr_cmp_lo;
    logic            wr_cmp_hi;
    logic            wr_ctrl;
    logic            wr_pre;
    logic [2*DW-1:0] mtime;
    logic [2*DW-1:0] mtime_nxt;
    logic [2*DW-1:0] mtimecmp;
    logic            ten;
    logic            een;
    logic            tick;
    logic [DW-1:0]   prescale;
    logic [DW-1:0]   pcnt;
    logic [DW-1:0]   pcnt_nxt;
    logic [DW-1:0]   rd_mux;
    logic [SS-1:0]   sync;
    logic            dly;
    logic [1:0]      unused_addr;

    assign unused_addr = addr_i[1:0];

    // Word-address decode and one write strobe per register
    always_comb begin
        idx         = addr_i[AW-1:2];
        wr          = sel_i & we_i;
        rd          = sel_i & ~we_i;
        wr_mtime_lo = wr && (idx == R_MTIME_LO);
        wr_mtime_hi = wr && (idx == R_MTIME_HI);
        wr_cmp_lo   = wr && (idx == R_CMP_LO);
        wr_cmp_hi   = wr && (idx == R_CMP_HI);
        wr_ctrl     = wr && (idx == R_CTRL);
        wr_pre      = wr && (idx == R_PRESCALE);
    end

    // Prescaler: tick on reaching PRESCALE; any CTRL or PRESCALE write restarts the count
    always_comb begin
        tick     = ten && (pcnt == prescale);
        pcnt_nxt = (wr_ctrl || wr_pre) ? '0 : !ten ? pcnt : tick ? '0 : pcnt + DW'(1);
    end

    // Next mtime: a bus write to either half beats the tick and suppresses the increment
    always_comb begin
        mtime_nxt = mtime;
        if (wr_mtime_lo)
            mtime_nxt[DW-1:0] = wdata_i;
        else if (wr_mtime_hi)
            mtime_nxt[2*DW-1:DW] = wdata_i;
        else if (tick)
            mtime_nxt = mtime + (2*DW)'(1);
    end

    // Read multiplexer over the register window; unmapped words read zero
    always_comb begin
        rd_mux = '0;
        case (idx)
            R_MTIME_LO: rd_mux = mtime[DW-1:0];
            R_MTIME_HI: rd_mux = mtime[2*DW-1:DW];
            R_CMP_LO:   rd_mux = mtimecmp[DW-1:0];
            R_CMP_HI:   rd_mux = mtimecmp[2*DW-1:DW];
            R_CTRL:     rd_mux = {{(DW-2){1'b0}}, een, ten};
            R_PRESCALE: rd_mux = prescale;
            default:    rd_mux = '0;
        endcase
    end

    // Timer state: counter, prescaler count and mtime
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt  <= '0;
            mtime <= '0;
        end else begin
            pcnt  <= pcnt_nxt;
            mtime <= mtime_nxt;
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp <= '1;
            ten      <= 1'b0;
            een      <= 1'b0;
            prescale <= '0;
        end else begin
            if (wr_cmp_lo)
                mtimecmp[DW-1:0] <= wdata_i;
            if (wr_cmp_hi)
                mtimecmp[2*DW-1:DW] <= wdata_i;
            if (wr_ctrl) begin
                ten <= wdata_i[0];
                een <= wdata_i[1];
            end
            if (wr_pre)
                prescale <= wdata_i;
        end
    end

    // Registered read port: data holds between reads, valid pulses once per read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= rd;
            if (rd)
                rdata_o <= rd_mux;
        end
    end

    // Timer interrupt level from the current register values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            t_intr <= 1'b0;
        else
            t_intr <= ten && (mtime >= mtimecmp);
    end

    // External pin synchronizer, delay flop and gated rising-edge pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync   <= '0;
            dly    <= 1'b0;
            e_intr <= 1'b0;
        end else begin
            sync   <= {sync[SS-2:0], e_irq_i};
            dly    <= sync[SS-1];
            e_intr <= een & sync[SS-1] & ~dly;
        end
    end

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// tb_mtimer_irq_gen: directed and randomized checks of mtimer_irq_gen against a behavioural model
module tb_mtimer_irq_gen;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SS = 2;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          sel_i   = 1'b0;
    logic          we_i    = 1'b0;
    logic [AW-1:0] addr_i  = '0;
    logic [DW-1:0] wdata_i = '0;
    logic          e_irq_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          t_intr;
    logic          e_intr;

    int checks = 0;
    int errors = 0;

    mtimer_irq_gen #(.DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .rvalid_o(rvalid_o),
        .e_irq_i (e_irq_i),
        .t_intr  (t_intr),
        .e_intr  (e_intr)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: register contents plus a history of sampled pin values
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [1:0]  m_ctrl;
    logic [31:0] m_pre;
    logic [31:0] m_since;
    logic [SS:0] m_hist;
    logic        x_t;
    logic        x_e;
    logic        x_v;
    logic [31:0] x_d;
    logic [2:0]  m_ix;
    logic        m_wr;
    logic        m_tick;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] regval(input logic [2:0] ix);
        case (ix)
            3'd0:    return m_time[31:0];
            3'd1:    return m_time[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {30'b0, m_ctrl};
            3'd5:    return m_pre;
            default: return 32'h0;
        endcase
    endfunction

    // Model step on each edge, then compare all outputs just after the edge
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_time = 64'h0; m_cmp = '1; m_ctrl = 2'b0; m_pre = 0; m_since = 0;
            m_hist = '0; x_t = 0; x_e = 0; x_v = 0; x_d = 0;
        end else begin
            m_ix   = addr_i[4:2];
            m_wr   = sel_i && we_i;
            x_t    = m_ctrl[0] && (m_time >= m_cmp);
            x_e    = m_ctrl[1] && m_hist[SS-1] && !m_hist[SS];
            x_v    = sel_i && !we_i;
            if (x_v)
                x_d = regval(m_ix);
            m_tick = m_ctrl[0] && (m_since == m_pre);
            if (m_wr && (m_ix == 3'd4 || m_ix == 3'd5))
                m_since = 0;
            else if (m_ctrl[0])
                m_since = m_tick ? 0 : m_since + 1;
            if (m_wr && m_ix == 3'd0)
                m_time[31:0] = wdata_i;
            else if (m_wr && m_ix == 3'd1)
                m_time[63:32] = wdata_i;
            else if (m_tick)
                m_time = m_time + 64'd1;
            if (m_wr && m_ix == 3'd2) m_cmp[31:0] = wdata_i;
            if (m_wr && m_ix == 3'd3) m_cmp[63:32] = wdata_i;
            if (m_wr && m_ix == 3'd4) m_ctrl = wdata_i[1:0];
            if (m_wr && m_ix == 3'd5) m_pre = wdata_i;
            m_hist = {m_hist[SS-1:0], e_irq_i};
        end
        #1;
        if (rst_ni) begin
            chk("rvalid", rvalid_o, x_v);
            chk("rdata", rdata_o, x_d);
            chk("t_intr", t_intr, x_t);
            chk("e_intr", e_intr, x_e);
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel_i = 1; we_i = 1; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        sel_i = 0; we_i = 0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        sel_i = 1; we_i = 0; addr_i = a;
        @(negedge clk_i);
        sel_i = 0;
        chk({name, "_rvalid"}, rvalid_o, 1);
        chk(name, rdata_o, exp);
    endtask

    task automatic pulse(output int cnt, output int at);
        cnt = 0; at = -1; e_irq_i = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_i);
            if (i == 5) e_irq_i = 0;
            if (e_intr) begin cnt++; at = i; end
        end
    endtask

    function automatic logic [31:0] pick(input logic [2:0] ix);
        logic [31:0] v;
        v = $urandom;
        case (ix)
            3'd0: v = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : v;
            3'd1: v = ($urandom_range(0, 2) == 0) ? m_time[63:32] : ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : v;
            3'd2: v = m_time[31:0] + 32'($urandom_range(0, 30)) - 32'd10;
            3'd3: v = m_time[63:32] + 32'($urandom_range(0, 1));
            3'd4: v[0] = ($urandom_range(0, 3) != 0);
            3'd5: v = 32'($urandom_range(0, 3));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int cnt, at;
        logic [2:0] ix;
        int r;
        repeat (3) @(negedge clk_i);
        rst_ni = 1;
        chk("rst_t_intr", t_intr, 0);
        chk("rst_e_intr", e_intr, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        rd(5'h00, 32'h0, "rst_mtime_lo");
        rd(5'h04, 32'h0, "rst_mtime_hi");
        rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        @(negedge clk_i);
        chk("rvalid_drop", rvalid_o, 0);
        chk("rdata_hold", rdata_o, 32'hFFFF_FFFF);

        wr(5'h14, 3);
        wr(5'h10, 1);
        repeat (40) @(negedge clk_i);
        rd(5'h00, 10, "presc_mtime_40");
        repeat (3) @(negedge clk_i);
        rd(5'h00, 11, "presc_mtime_44");

        wr(5'h10, 0);
        wr(5'h14, 0);
        wr(5'h04, 0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h10, 1);
        rd(5'h00, 32'hFFFF_FFFE, "carry_lo0");
        rd(5'h00, 32'hFFFF_FFFF, "carry_lo1");
        rd(5'h00, 32'h0, "carry_lo2");
        rd(5'h04, 32'h1, "carry_hi");

        wr(5'h10, 0);
        wr(5'h0C, 0);
        wr(5'h08, 20);
        wr(5'h04, 0);
        wr(5'h00, 0);
        wr(5'h10, 1);
        repeat (20) @(negedge clk_i);
        chk("t_intr_before", t_intr, 0);
        @(negedge clk_i);
        chk("t_intr_rise", t_intr, 1);
        repeat (5) @(negedge clk_i);
        chk("t_intr_level", t_intr, 1);
        wr(5'h08, 100);
        chk("t_intr_wr_cycle", t_intr, 1);
        @(negedge clk_i);
        chk("t_intr_drop", t_intr, 0);

        wr(5'h10, 3);
        pulse(cnt, at);
        chk("e_pulse_count", cnt, 1);
        chk("e_pulse_latency", at, 3);
        wr(5'h10, 1);
        repeat (4) @(negedge clk_i);
        pulse(cnt, at);
        chk("e_masked_count", cnt, 0);

        wr(5'h0C, 0);
        wr(5'h08, 0);
        repeat (2) @(negedge clk_i);
        chk("t_intr_pre_reset", t_intr, 1);
        #2 rst_ni = 0;
        #1;
        chk("async_t_intr", t_intr, 0);
        chk("async_rdata", rdata_o, 0);
        chk("async_rvalid", rvalid_o, 0);
        chk("async_e_intr", e_intr, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        rd(5'h10, 0, "ctrl_after_reset");
        rd(5'h00, 0, "mtime_after_reset");
        rd(5'h0C, 32'hFFFF_FFFF, "cmp_after_reset");

        for (int n = 0; n < 4000; n++) begin
            r  = $urandom_range(0, 99);
            ix = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) e_irq_i = ~e_irq_i;
            if (r < 40) begin
                sel_i = 0; we_i = 0;
            end else begin
                sel_i   = 1;
                we_i    = (r < 70);
                addr_i  = {ix, 2'($urandom_range(0, 3))};
                wdata_i = pick(ix);
            end
            @(negedge clk_i);
        end
        sel_i = 0; we_i = 0; e_irq_i = 0;
        repeat (6) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
